// File: rtl/mul_if.sv
// Operand/result bundle between the control unit and the iterative multiplier.
// Valid/ready contract: Start is sampled only while Busy is low; Result/MulFlags are valid in the cycle Done is high.
interface mul_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] Acc;
  logic        Accumulate;
  logic        Start;
  logic [31:0] Result;
  logic [1:0]  MulFlags;
  logic        Busy;
  logic        Done;

  modport master (
    output SrcA, SrcB, Acc, Accumulate, Start,
    input  Result, MulFlags, Busy, Done
  );

  modport slave (
    input  SrcA, SrcB, Acc, Accumulate, Start,
    output Result, MulFlags, Busy, Done
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add 32-bit MUL/MLA: one multiplier bit per RUN cycle, early exit
// once the remaining multiplier is zero, registered low-32 result plus {N,Z}.
module mul_unit (
  input  logic       clk,
  input  logic       reset_n,
  mul_if.slave       bus,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [31:0] mcand_q,  mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q,    acc_d;
  logic [4:0]  count_q,  count_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  flags_q,  flags_d;

  logic [31:0] acc_step;
  logic [31:0] mplier_step;
  logic        run_last;

  // One shift-add step; the exit test looks at the post-update multiplier.
  assign acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_step = {1'b0, mplier_q[31:1]};
  assign run_last    = (mplier_step == 32'd0) || (count_q == 5'd31);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          mcand_d  = bus.SrcA;
          mplier_d = bus.SrcB;
          acc_d    = bus.Accumulate ? bus.Acc : 32'd0;
          count_d  = 5'd0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = mplier_step;
        count_d  = count_q + 5'd1;
        if (run_last) begin
          result_d = acc_step;
          flags_d  = {acc_step[31], (acc_step == 32'd0)};
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      count_q  <= 5'd0;
      result_q <= 32'd0;
      flags_q  <= 2'b01;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Status outputs decode flops only, so no input reaches an output combinationally.
  assign bus.Result   = result_q;
  assign bus.MulFlags = flags_q;
  assign bus.Busy     = (state_q != ST_IDLE);
  assign bus.Done     = (state_q == ST_DONE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: scoreboard of expected {N,Z,Result} checked on every Done pulse.
module tb_mul_unit;

  logic       clk;
  logic       reset_n;
  logic [1:0] state_dbg;
  int         vectors;
  int         miscompares;
  logic [33:0] exp_q[$];

  mul_if mif ();

  mul_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif.slave),
    .state_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  function automatic int model_k(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++)
      if (b[i]) k = i + 1;
    return k;
  endfunction

  function automatic logic [33:0] model_res(input logic [31:0] a, b, c, input logic accum);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    r = p[31:0] + (accum ? c : 32'd0);
    return {r[31], (r == 32'd0), r};
  endfunction

  // Scoreboard: every Done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mif.Done === 1'b1) begin
      if (exp_q.size() == 0)
        check("unexpected_done", 34'd1, 34'd0);
      else
        check("result", {mif.MulFlags, mif.Result}, exp_q.pop_front());
    end
  end

  task automatic wait_done(input int k);
    int lat;
    lat = 1;
    while (mif.Done !== 1'b1 && lat < 40) begin
      check("busy_run", {33'd0, mif.Busy}, 34'd1);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, k + 1);
    check("busy_done", {33'd0, mif.Busy}, 34'd1);
  endtask

  task automatic run_op(input logic [31:0] a, b, c, input logic accum, input bit poke_done);
    exp_q.push_back(model_res(a, b, c, accum));
    @(negedge clk);
    mif.SrcA = a; mif.SrcB = b; mif.Acc = c; mif.Accumulate = accum; mif.Start = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    mif.SrcA = $urandom; mif.SrcB = $urandom; mif.Acc = $urandom;
    mif.Accumulate = 1'($urandom_range(0, 1));
    wait_done(model_k(b));
    if (poke_done) mif.Start = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    check("idle_after", {33'd0, mif.Busy}, 34'd0);
    @(negedge clk);
    check("idle_hold", {33'd0, mif.Busy}, 34'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    mif.SrcA = '0; mif.SrcB = '0; mif.Acc = '0; mif.Accumulate = 1'b0; mif.Start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", {2'b00, mif.Result}, 34'd0);
    check("rst_flags", {32'd0, mif.MulFlags}, 34'd1);
    check("rst_busy", {33'd0, mif.Busy}, 34'd0);
    check("rst_done", {33'd0, mif.Done}, 34'd0);
    reset_n = 1'b1;

    run_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(32'd9, 32'd0, 32'd7, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 1'b0);
    run_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op($urandom, 32'($urandom_range(0, 32'h000F_FFFF)), $urandom, 1'($urandom_range(0, 1)), 1'b0);

    // Start held high: second operation accepted only from the IDLE cycle.
    exp_q.push_back(model_res(32'd6, 32'd7, 32'd0, 1'b0));
    exp_q.push_back(model_res(32'd6, 32'd7, 32'd0, 1'b0));
    @(negedge clk);
    mif.SrcA = 32'd6; mif.SrcB = 32'd7; mif.Acc = 32'd0; mif.Accumulate = 1'b0; mif.Start = 1'b1;
    @(negedge clk);
    wait_done(3);
    @(negedge clk);
    check("held_idle", {33'd0, mif.Busy}, 34'd0);
    @(negedge clk);
    check("held_second", {33'd0, mif.Busy}, 34'd1);
    mif.Start = 1'b0;
    wait_done(3);
    @(negedge clk);
    check("held_end", {33'd0, mif.Busy}, 34'd0);

    // Asynchronous reset in cycle 10 of a 32-cycle operation.
    @(negedge clk);
    mif.SrcA = 32'hFFFF_FFFF; mif.SrcB = 32'hFFFF_FFFF; mif.Accumulate = 1'b0; mif.Start = 1'b1;
    @(negedge clk);
    mif.Start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {33'd0, mif.Busy}, 34'd0);
    check("midrst_result", {2'b00, mif.Result}, 34'd0);
    check("midrst_flags", {32'd0, mif.MulFlags}, 34'd1);
    check("midrst_done", {33'd0, mif.Done}, 34'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);

    check("queue_empty", exp_q.size(), 34'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
